// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns for the decryption round loop.
// A 128-bit state is accepted on a valid/ready handshake. The block then
// transforms COLS_PER_CYC columns per clock, in place in a work register, and
// presents the finished state on a second valid/ready handshake.
// COLS_PER_CYC may be 1, 2 or 4. One pass over the whole state takes
// 4/COLS_PER_CYC clocks.
// Byte layout: column c = [127-32c -: 32], and row 0 is the column MSB byte.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Column-counter increment. For COLS_PER_CYC=4 it truncates to 0, which
    // is correct because a single pass covers every column.
    localparam logic [1:0] COL_STEP_C = 2'(COLS_PER_CYC);
    // Start column of the pass that finishes column 3.
    localparam logic [1:0] LAST_COL_C = 2'(4 - COLS_PER_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [1:0]     col_idx_r;
    logic [1:0]     col_idx_nxt_s;
    logic [127:0]   work_r;
    logic [127:0]   work_nxt_s;
    logic [127:0]   work_mixed_s;
    logic [1:0]     col_sel_s;
    logic           out_valid_r;
    logic           busy_r;
    logic           in_ready_s;

    // GF(2^8) multiply by 2, reduced modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] r;
        if (b[7]) begin
            r = {b[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {b[6:0], 1'b0};
        end
        return r;
    endfunction

    // InvMixColumns applied to a single 32-bit column (row 0 in the MSB byte).
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Replace the columns selected by col_idx with their transformed values.
    always_comb begin
        work_mixed_s = work_r;
        col_sel_s    = 2'd0;
        for (int k = 0; k < COLS_PER_CYC; k++) begin
            col_sel_s = col_idx_r + 2'(k);
            work_mixed_s[{~col_sel_s, 5'd0} +: 32] = inv_mix_col(work_r[{~col_sel_s, 5'd0} +: 32]);
        end
    end

    // Input acceptance: always in IDLE; in DONE only when the result is being taken.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_DONE: in_ready_s = out_ready;
            ST_BUSY: in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Next-state, column counter and work register update.
    always_comb begin
        state_nxt_s   = state_r;
        col_idx_nxt_s = col_idx_r;
        work_nxt_s    = work_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nxt_s    = in_data;
                    col_idx_nxt_s = 2'd0;
                    state_nxt_s   = ST_BUSY;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                work_nxt_s    = work_mixed_s;
                col_idx_nxt_s = col_idx_r + COL_STEP_C;
                if (col_idx_r == LAST_COL_C) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_nxt_s    = in_data;
                        col_idx_nxt_s = 2'd0;
                        state_nxt_s   = ST_BUSY;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                col_idx_nxt_s = 2'd0;
            end
        endcase
    end

    // State, datapath and registered status flags. Reset discards any partial transform.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            col_idx_r   <= 2'd0;
            work_r      <= 128'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            col_idx_r   <= col_idx_nxt_s;
            work_r      <= work_nxt_s;
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_BUSY);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = work_r;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq.
// Three instances (COLS_PER_CYC = 1, 2, 4) are checked against a
// byte-matrix GF(2^8) reference model.
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] in_data_a   [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] out_data_a  [3];
    logic         busy_a      [3];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        inv_mix_columns_seq #(.COLS_PER_CYC(CPC)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_data   (in_data_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_data  (out_data_a[g]),
            .busy      (busy_a[g])
        );
    end

    // General GF(2^8) multiply (shift-and-add, modulus 0x11b).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // MixColumns (inv=0) or InvMixColumns (inv=1) as a circulant matrix product.
    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inv);
        logic [7:0]   coef [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++)
                    b = b ^ gmul(coef[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
                r[127-32*c-8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic int npass(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int d);
        int cnt;
        cnt = 0;
        while (!in_ready_a[d] && cnt < 50) begin
            step();
            cnt++;
        end
        if (cnt >= 50) chk("ready_timeout", 128'(in_ready_a[d]), 128'd1);
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid_a[d] && lat < 20) begin
            step();
            lat++;
        end
        if (lat >= 20) chk("valid_timeout", 128'(out_valid_a[d]), 128'd1);
    endtask

    // Send one state, report the result and the accept-to-out_valid clock count.
    task automatic transact(input int d, input logic [127:0] data,
                            output logic [127:0] res, output int lat);
        wait_ready(d);
        in_valid_a[d] = 1'b1;
        in_data_a[d]  = data;
        step();
        in_valid_a[d] = 1'b0;
        wait_valid(d, lat);
        res = out_data_a[d];
        out_ready_a[d] = 1'b1;
        step();
        out_ready_a[d] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        logic [127:0] orig;
        logic [127:0] sa;
        logic [127:0] sb;
        logic [127:0] fixed_pat [3];
        logic [127:0] bb_in   [3];
        logic [127:0] bb_got  [3];
        int           bb_when [3];
        int           lat;
        int           idx;
        int           nout;
        logic         acc;

        for (int d = 0; d < 3; d++) begin
            in_valid_a[d]  = 1'b0;
            in_data_a[d]   = 128'd0;
            out_ready_a[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready",  128'(in_ready_a[d]),  128'd1);
            chk("rst_out_valid", 128'(out_valid_a[d]), 128'd0);
            chk("rst_busy",      128'(busy_a[d]),      128'd0);
            chk("rst_out_data",  out_data_a[d],        128'd0);
        end

        // FIPS-197 vector
        transact(0, 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, res, lat);
        chk("fips_out", res, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
        chk("fips_lat", 128'(lat), 128'd4);

        // Fixed points
        fixed_pat[0] = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
        fixed_pat[1] = 128'h01010101_01010101_01010101_01010101;
        fixed_pat[2] = 128'd0;
        for (int i = 0; i < 3; i++) begin
            transact(0, fixed_pat[i], res, lat);
            chk("fixed_point", res, fixed_pat[i]);
        end

        // Direct comparison against the inverse model
        for (int i = 0; i < 50; i++) begin
            orig = rand_state();
            transact(0, orig, res, lat);
            chk("model_inv", res, mix_state(orig, 1'b1));
        end

        // Round trip through the forward model, for every COLS_PER_CYC
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                orig = rand_state();
                transact(d, mix_state(orig, 1'b0), res, lat);
                chk("roundtrip", res, orig);
                chk("roundtrip_lat", 128'(lat), 128'(npass(d)));
            end
        end

        // Back-pressure in DONE
        sa = rand_state();
        sb = rand_state();
        wait_ready(0);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = sa;
        step();
        in_valid_a[0] = 1'b0;
        chk("bp_busy_after_accept", 128'(busy_a[0]), 128'd1);
        chk("bp_in_ready_busy",     128'(in_ready_a[0]), 128'd0);
        wait_valid(0, lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
            chk("bp_out_data",  out_data_a[0], mix_state(sa, 1'b1));
            chk("bp_in_ready",  128'(in_ready_a[0]), 128'd0);
            step();
        end
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = sb;
        out_ready_a[0] = 1'b1;
        #1;
        chk("bp_in_ready_release", 128'(in_ready_a[0]), 128'd1);
        step();
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        chk("bp_accepted_busy", 128'(busy_a[0]), 128'd1);
        chk("bp_valid_dropped", 128'(out_valid_a[0]), 128'd0);
        wait_valid(0, lat);
        chk("bp_second_out", out_data_a[0], mix_state(sb, 1'b1));
        out_ready_a[0] = 1'b1;
        step();
        out_ready_a[0] = 1'b0;

        // Back-to-back stream of three states
        for (int i = 0; i < 3; i++) begin
            bb_in[i]   = rand_state();
            bb_got[i]  = 128'bx;
            bb_when[i] = -1;
        end
        wait_ready(0);
        idx  = 0;
        nout = 0;
        in_valid_a[0]  = 1'b1;
        in_data_a[0]   = bb_in[0];
        out_ready_a[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && nout < 3; cyc++) begin
            acc = in_valid_a[0] && in_ready_a[0];
            if (out_valid_a[0]) begin
                bb_got[nout]  = out_data_a[0];
                bb_when[nout] = cyc;
                nout++;
            end
            step();
            if (acc) begin
                idx++;
                if (idx < 3) in_data_a[0] = bb_in[idx];
                else         in_valid_a[0] = 1'b0;
            end
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_data", bb_got[i], mix_state(bb_in[i], 1'b1));
            chk("b2b_cycle", 128'(bb_when[i]), 128'(5 * (i + 1)));
        end

        // Reset during the second BUSY clock
        wait_ready(0);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = rand_state();
        step();
        in_valid_a[0] = 1'b0;
        chk("mid_rst_busy_before", 128'(busy_a[0]), 128'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_in_ready",  128'(in_ready_a[0]),  128'd1);
        chk("mid_rst_out_valid", 128'(out_valid_a[0]), 128'd0);
        chk("mid_rst_busy",      128'(busy_a[0]),      128'd0);
        chk("mid_rst_out_data",  out_data_a[0],        128'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_rst_no_stale_valid", 128'(out_valid_a[0]), 128'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
